syn_pipeline_hazard_ctrl: RTL and testbench

- Consumer of the data-collision detector's `load_use` output in the 5-stage pipeline.
- Also takes branch/jump resolution and syscall halt requests.
- Produces per-stage hold/flush controls for the PC, IF/ID and ID/EX registers, plus the `stalled` feedback that tells the collision detector a bubble entered EX.
- Keeps saturating stall and flush event counters for the debug display.

---
 rtl/syn_pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/syn_pipeline_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/syn_pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_syn_pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/syn_pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package syn_pipeline_hazard_ctrl_pkg;

  // Controller state, 2-bit encoding
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hz_state_t;

  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned DRAIN_CYCLES_DEF = 2;
  localparam int unsigned DRAIN_CYCLES_MAX = 7;
  localparam int unsigned DCNT_W           = 3;

endpackage

// File: rtl/syn_pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up by one on inc, holding at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/syn_pipeline_hazard_ctrl.sv
// Per-stage hold/flush control for the 5-stage pipeline: load-use stalls,
// branch/jump flushes, halt drain, plus stall/flush event counters.
module syn_pipeline_hazard_ctrl
  import syn_pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             halt_req,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             stalled,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Drain counter preload: DRAIN_CYCLES cycles spent in DRAIN in total
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

  hz_state_t         state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic              stall_inc;
  logic              flush_inc;

  // State and drain counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next-state and zero-latency control outputs
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    stalled   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (!en) begin
      // Frozen pipeline: hold front end, insert nothing, keep state
      if_stall = 1'b1;
      id_stall = 1'b1;
    end else begin
      case (state)
        RUN, LSTALL: begin
          state_nxt = RUN;
          if (halt_req) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_flush  = 1'b1;
            state_nxt = DRAIN;
            dcnt_nxt  = DCNT_LOAD;
          end else if (branch_taken) begin
            // Younger load_use/jump are on the wrong path
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            flush_inc = 1'b1;
          end else if (load_use && (state == RUN)) begin
            // Jump in ID is retried once the bubble has gone in
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_flush  = 1'b1;
            stalled   = 1'b1;
            stall_inc = 1'b1;
            state_nxt = LSTALL;
          end else if (jump) begin
            id_flush  = 1'b1;
            flush_inc = 1'b1;
          end
        end
        DRAIN: begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
          if (dcnt == '0) begin
            state_nxt = HALTED;
          end else begin
            dcnt_nxt = dcnt - DCNT_W'(1);
          end
        end
        HALTED: begin
          if_stall = 1'b1;
          id_stall = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // Halt indication straight from the state
  assign halted = (state == HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_syn_pipeline_hazard_ctrl.sv
// Directed self-checking bench for syn_pipeline_hazard_ctrl (CNT_W=3, DRAIN_CYCLES=2).
module tb_syn_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             load_use;
  logic             branch_taken;
  logic             jump;
  logic             halt_req;
  logic             if_stall;
  logic             id_stall;
  logic             id_flush;
  logic             ex_flush;
  logic             stalled;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Control bundle order: {if_stall, id_stall, id_flush, ex_flush, stalled, halted}
  localparam logic [5:0] C_IDLE   = 6'b000000;
  localparam logic [5:0] C_LSTALL = 6'b110110;
  localparam logic [5:0] C_BRANCH = 6'b001100;
  localparam logic [5:0] C_JUMP   = 6'b001000;
  localparam logic [5:0] C_FREEZE = 6'b110000;
  localparam logic [5:0] C_DRAIN  = 6'b110100;
  localparam logic [5:0] C_HALTED = 6'b110001;

  syn_pipeline_hazard_ctrl #(
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .jump         (jump),
    .halt_req     (halt_req),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .stalled      (stalled),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs {en,load_use,branch_taken,jump,halt_req} at negedge,
  // check controls before the edge, then move #1 past the rising edge
  task automatic cyc(input string tag, input logic [4:0] in, input logic [5:0] exp_ctrl);
    @(negedge clk);
    {en, load_use, branch_taken, jump, halt_req} = in;
    #1;
    check_eq(tag, 32'({if_stall, id_stall, id_flush, ex_flush, stalled, halted}), 32'(exp_ctrl));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int exp_stall, input int exp_flush);
    check_eq({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check_eq({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    {en, load_use, branch_taken, jump, halt_req} = 5'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {en, load_use, branch_taken, jump, halt_req} = 5'b0;

    // Reset and idle
    do_reset(2);
    check_cnts("reset", 0, 0);
    cyc("idle_en0", 5'b00000, C_FREEZE);
    cyc("idle_run", 5'b10000, C_IDLE);
    check_cnts("idle", 0, 0);

    // Load-use for two cycles: second one lands in LSTALL and is ignored
    cyc("lu_first", 5'b11000, C_LSTALL);
    cyc("lu_second", 5'b11000, C_IDLE);
    check_cnts("lu", 1, 0);

    // Branch wins over load_use
    cyc("br_lu", 5'b11100, C_BRANCH);
    check_cnts("br_lu", 1, 1);

    // Jump alone, then jump with load_use, then jump retried from LSTALL
    cyc("jump", 5'b10010, C_JUMP);
    check_cnts("jump", 1, 2);
    cyc("jump_lu", 5'b11010, C_LSTALL);
    check_cnts("jump_lu", 2, 2);
    cyc("jump_retry", 5'b10010, C_JUMP);
    check_cnts("jump_retry", 2, 3);

    // Branch taken while in LSTALL still flushes
    cyc("lu_pre_br", 5'b11000, C_LSTALL);
    cyc("br_in_lstall", 5'b10100, C_BRANCH);
    check_cnts("br_in_lstall", 3, 4);

    // Disabled: freeze, no bubble, counters hold
    cyc("en0_lu", 5'b01000, C_FREEZE);
    cyc("en0_br", 5'b00100, C_FREEZE);
    check_cnts("en0", 3, 4);

    // Saturation of the 3-bit stall counter over 10 events
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("sat_lu%0d", i), 5'b11000, C_LSTALL);
      cyc($sformatf("sat_gap%0d", i), 5'b10000, C_IDLE);
      if (i == 3) check_eq("sat_mid_stall_cnt", 32'(stall_cnt), 32'd7);
    end
    check_cnts("sat", 7, 4);

    // Reset mid-stall: back to RUN with nothing pending
    cyc("lu_pre_rst", 5'b11000, C_LSTALL);
    do_reset(1);
    check_cnts("rst_mid_stall", 0, 0);
    cyc("post_rst_idle", 5'b10000, C_IDLE);
    cyc("post_rst_lu", 5'b11000, C_LSTALL);
    check_cnts("post_rst", 1, 0);
    cyc("post_rst_gap", 5'b10000, C_IDLE);

    // Halt: request cycle, two drain cycles, then permanent halt
    cyc("halt_req", 5'b10001, C_DRAIN);
    cyc("drain0_br", 5'b11110, C_DRAIN);
    cyc("drain0_en0", 5'b01110, C_FREEZE);
    cyc("drain1", 5'b10001, C_DRAIN);
    cyc("halted_br", 5'b10100, C_HALTED);
    cyc("halted_lu", 5'b11000, C_HALTED);
    cyc("halted_en0", 5'b01000, C_HALTED);
    check_cnts("halted", 1, 0);

    // Reset leaves HALTED
    do_reset(1);
    cyc("unhalt_idle", 5'b10000, C_IDLE);
    cyc("unhalt_jump", 5'b10010, C_JUMP);
    check_cnts("unhalt", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
